mram_serial_burst_ctrl: RTL and testbench

Parametrised serial-to-MRAM access controller: shifts a serial address (and write data) in LSB-first, runs one or more asynchronous-SRAM-style MRAM access cycles with programmable wait states, and returns read data serially LSB-first. It adds burst transfers with address auto-increment, per-byte-lane enables generalised to any data width, and a start/busy/done handshake. It sits between the serial host-side logic and the MRAM pins.

---
 rtl/mram_serial_burst_ctrl_if.sv | 42 ++++
 rtl/mram_serial_burst_ctrl.sv | 141 ++++++++++++++
 tb/tb_mram_serial_burst_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mram_serial_burst_ctrl_if.sv
// Host-side handshake/serial lines and MRAM pin bundle for mram_serial_burst_ctrl.
// The master side is the host plus the MRAM array; the controller uses the slave side.
interface mram_serial_burst_ctrl_if #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 20,
  parameter int BURST_MAX = 8
);
  localparam int NB   = DATA_W / 8;
  localparam int BL_W = $clog2(BURST_MAX + 1);

  logic              start;
  logic              rw;
  logic [NB-1:0]     byte_en;
  logic [BL_W-1:0]   burst_len;
  logic              addr_in;
  logic              data_in;
  logic              shift_en;
  logic              busy;
  logic              done;
  logic              ser_data_out;
  logic              ser_valid;
  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic [DATA_W-1:0] mram_rdata;
  logic              chip_en;
  logic              write_en;
  logic              out_en;
  logic [NB-1:0]     lane_en_n;

  modport master (
    output start, rw, byte_en, burst_len, addr_in, data_in, mram_rdata,
    input  shift_en, busy, done, ser_data_out, ser_valid,
           addr_out, data_out, data_oe, chip_en, write_en, out_en, lane_en_n
  );

  modport slave (
    input  start, rw, byte_en, burst_len, addr_in, data_in, mram_rdata,
    output shift_en, busy, done, ser_data_out, ser_valid,
           addr_out, data_out, data_oe, chip_en, write_en, out_en, lane_en_n
  );
endinterface

// File: rtl/mram_serial_burst_ctrl.sv
// Serial-to-MRAM burst controller: serial address/data in, async-SRAM-style
// access cycles with wait states, serial read data out, start/busy/done handshake.
module mram_serial_burst_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 20,
  parameter int WAIT_CYC  = 3,
  parameter int BURST_MAX = 8
) (
  input logic                  clk,
  input logic                  rst,
  mram_serial_burst_ctrl_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int BL_W  = $clog2(BURST_MAX + 1);
  localparam int MAXAD = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int MAXC  = (MAXAD > WAIT_CYC) ? MAXAD : WAIT_CYC;
  localparam int CNT_W = $clog2(MAXC + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC - 1);
  localparam logic [BL_W-1:0]  BL_MAX    = BL_W'(BURST_MAX);
  localparam logic [BL_W-1:0]  BL_ONE    = BL_W'(1);

  typedef enum logic [2:0] {
    IDLE, SHIFT_ADDR, SHIFT_DATA, ACCESS, RECOVER, SER_OUT, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [BL_W-1:0]   word_cnt, burst_eff, burst_req;
  logic              rw_q;
  logic [NB-1:0]     be_q;
  logic [ADDR_W-1:0] addr_reg, addr_q, addr_cur;
  logic [DATA_W-1:0] wdata, data_q, data_cur;
  logic [DATA_W-1:0] rdata, lane_mask;
  logic              more_after_recover, more_after_ser;

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < NB; i++)
      lane_mask[8*i +: 8] = {8{be_q[i]}};
  end

  assign burst_req = (bus.burst_len == '0)    ? BL_ONE :
                     (bus.burst_len > BL_MAX) ? BL_MAX : bus.burst_len;

  // word_cnt is bumped in RECOVER, so SER_OUT already sees the post-increment value
  assign more_after_recover = (word_cnt + BL_ONE) < burst_eff;
  assign more_after_ser     = word_cnt < burst_eff;

  // The last shifted bit lands in the same edge that opens ACCESS, so forward it
  assign addr_cur = (state == SHIFT_ADDR) ? {bus.addr_in, addr_reg[ADDR_W-1:1]} : addr_reg;
  assign data_cur = (state == SHIFT_DATA) ? {bus.data_in, wdata[DATA_W-1:1]}    : wdata;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (bus.start) state_nxt = SHIFT_ADDR;
      SHIFT_ADDR: if (cnt == ADDR_LAST) state_nxt = rw_q ? SHIFT_DATA : ACCESS;
      SHIFT_DATA: if (cnt == DATA_LAST) state_nxt = ACCESS;
      ACCESS:     if (cnt == WAIT_LAST) state_nxt = RECOVER;
      RECOVER:    state_nxt = rw_q ? (more_after_recover ? SHIFT_DATA : DONE) : SER_OUT;
      SER_OUT:    if (cnt == DATA_LAST) state_nxt = more_after_ser ? ACCESS : DONE;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.shift_en     = 1'b0;
    bus.busy         = (state != IDLE);
    bus.done         = 1'b0;
    bus.ser_valid    = 1'b0;
    bus.ser_data_out = 1'b0;
    bus.data_oe      = 1'b0;
    bus.chip_en      = 1'b1;
    bus.write_en     = 1'b1;
    bus.out_en       = 1'b1;
    bus.lane_en_n    = '1;
    case (state)
      SHIFT_ADDR, SHIFT_DATA: bus.shift_en = 1'b1;
      ACCESS: begin
        bus.chip_en   = 1'b0;
        bus.lane_en_n = ~be_q;
        bus.write_en  = ~rw_q;
        bus.out_en    = rw_q;
        bus.data_oe   = rw_q;
      end
      SER_OUT: begin
        bus.ser_valid    = 1'b1;
        bus.ser_data_out = rdata[0];
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.addr_out = addr_q;
  assign bus.data_out = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      word_cnt  <= '0;
      burst_eff <= '0;
      rw_q      <= 1'b0;
      be_q      <= '0;
      addr_reg  <= '0;
      addr_q    <= '0;
      wdata     <= '0;
      data_q    <= '0;
      rdata     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
      case (state)
        IDLE: if (bus.start) begin
          rw_q      <= bus.rw;
          be_q      <= bus.byte_en;
          burst_eff <= burst_req;
          word_cnt  <= '0;
        end
        SHIFT_ADDR: addr_reg <= addr_cur;
        SHIFT_DATA: wdata    <= data_cur;
        ACCESS: if (cnt == WAIT_LAST && !rw_q) rdata <= bus.mram_rdata & lane_mask;
        RECOVER: begin
          addr_reg <= addr_reg + ADDR_W'(1);
          word_cnt <= word_cnt + BL_ONE;
        end
        SER_OUT: rdata <= rdata >> 1;
        default: ;
      endcase
      if (state_nxt == ACCESS && state != ACCESS) begin
        addr_q <= addr_cur;
        if (rw_q) data_q <= data_cur;
      end
    end
  end
endmodule

// File: tb/tb_mram_serial_burst_ctrl.sv
// Directed bench for mram_serial_burst_ctrl: a cycle-indexed timing model derived
// from the command schedule is compared against the DUT on every cycle.
module tb_mram_serial_burst_ctrl;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 20;
  localparam int WAIT_CYC  = 3;
  localparam int BURST_MAX = 8;
  localparam int NB        = DATA_W / 8;
  localparam int BL_W      = $clog2(BURST_MAX + 1);
  localparam int PER       = DATA_W + WAIT_CYC + 1;

  logic clk;
  logic rst;

  mram_serial_burst_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_MAX(BURST_MAX)) bus ();

  mram_serial_burst_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_CYC(WAIT_CYC), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic              shift_en, busy, done, ser_valid, ser_data_out;
    logic              chip_en, write_en, out_en, data_oe;
    logic [NB-1:0]     lane_en_n;
    logic              is_access, is_wr_access;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              addr_in, data_in;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Current command as seen by the model
  logic              m_rw;
  logic [ADDR_W-1:0] m_addr;
  logic [NB-1:0]     m_be;
  int                m_bl;
  logic [DATA_W-1:0] m_wd [BURST_MAX];
  logic [DATA_W-1:0] m_rd [BURST_MAX];

  int  cyc;
  bit  active = 0;
  logic [ADDR_W-1:0] hold_addr = '0;

  // Observations used for the hand-computed literal checks
  int  first_strobe, last_strobe, access_cnt, shift_cnt, done_cnt, done_cyc, ser_idx;
  logic prev_chip;
  logic [DATA_W-1:0] first_data, ser_word;
  logic [NB-1:0]     first_lane;
  logic [ADDR_W-1:0] addr_log [$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("[TB] FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t model(input int c);
    exp_t e;
    int done_c, off, w, r;
    logic [DATA_W-1:0] mask, mdat;
    for (int i = 0; i < NB; i++) mask[8*i +: 8] = m_be[i] ? 8'hFF : 8'h00;
    done_c = ADDR_W + m_bl * PER + 1;
    e.shift_en = 0; e.ser_valid = 0; e.ser_data_out = 0;
    e.chip_en = 1; e.write_en = 1; e.out_en = 1; e.data_oe = 0;
    e.lane_en_n = '1; e.is_access = 0; e.is_wr_access = 0;
    e.addr = '0; e.data = '0; e.addr_in = 0; e.data_in = 0; e.rdata = 16'hBEEF;
    e.busy = (c >= 1 && c <= done_c);
    e.done = (c == done_c);
    if (c >= 1 && c <= ADDR_W) begin
      e.shift_en = 1;
      e.addr_in  = m_addr[c-1];
    end else if (c > ADDR_W && c < done_c) begin
      off = c - ADDR_W - 1;
      w   = off / PER;
      r   = off % PER;
      if (m_rw) begin
        if (r < DATA_W) begin
          e.shift_en = 1;
          e.data_in  = m_wd[w][r];
        end else if (r < DATA_W + WAIT_CYC) begin
          e.is_access = 1; e.is_wr_access = 1;
          e.chip_en = 0; e.write_en = 0; e.data_oe = 1; e.lane_en_n = ~m_be;
          e.addr = m_addr + ADDR_W'(w);
          e.data = m_wd[w];
        end
      end else begin
        if (r < WAIT_CYC) begin
          e.is_access = 1;
          e.chip_en = 0; e.out_en = 0; e.lane_en_n = ~m_be;
          e.addr  = m_addr + ADDR_W'(w);
          e.rdata = (r == WAIT_CYC - 1) ? m_rd[w] : ~m_rd[w];
        end else if (r > WAIT_CYC) begin
          mdat = m_rd[w] & mask;
          e.ser_valid    = 1;
          e.ser_data_out = mdat[r-WAIT_CYC-1];
        end
      end
    end
    return e;
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    exp_t e;
    if (active) begin
      e = model(cyc);
      if (e.is_access) hold_addr = e.addr;
      check_output("shift_en", bus.shift_en, e.shift_en);
      check_output("busy", bus.busy, e.busy);
      check_output("done", bus.done, e.done);
      check_output("ser_valid", bus.ser_valid, e.ser_valid);
      check_output("ser_data_out", bus.ser_data_out, e.ser_data_out);
      check_output("chip_en", bus.chip_en, e.chip_en);
      check_output("write_en", bus.write_en, e.write_en);
      check_output("out_en", bus.out_en, e.out_en);
      check_output("data_oe", bus.data_oe, e.data_oe);
      check_output("lane_en_n", bus.lane_en_n, e.lane_en_n);
      check_output("addr_out", bus.addr_out, hold_addr);
      if (e.is_wr_access) check_output("data_out", bus.data_out, e.data);
      if (!bus.chip_en) begin
        if (first_strobe < 0) begin
          first_strobe = cyc;
          first_data   = bus.data_out;
          first_lane   = bus.lane_en_n;
        end
        last_strobe = cyc;
        if (prev_chip) begin
          access_cnt++;
          addr_log.push_back(bus.addr_out);
        end
      end
      prev_chip = bus.chip_en;
      if (bus.shift_en) shift_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.ser_valid && ser_idx < DATA_W) begin
        ser_word[ser_idx] = bus.ser_data_out;
        ser_idx++;
      end
    end
  end

  task automatic apply_stimulus(input logic rw, input logic [ADDR_W-1:0] addr,
                                input logic [NB-1:0] be, input logic [BL_W-1:0] bl,
                                input bit pulses, input int abort_cyc);
    exp_t e;
    int done_c;
    m_rw = rw; m_addr = addr; m_be = be;
    m_bl = (bl == 0) ? 1 : ((int'(bl) > BURST_MAX) ? BURST_MAX : int'(bl));
    done_c = ADDR_W + m_bl * PER + 1;
    first_strobe = -1; last_strobe = -1; access_cnt = 0; shift_cnt = 0;
    done_cnt = 0; done_cyc = -1; ser_idx = 0; prev_chip = 1;
    first_data = '0; first_lane = '1; ser_word = '0;
    addr_log.delete();
    @(posedge clk); #1;
    bus.start = 1; bus.rw = rw; bus.byte_en = be; bus.burst_len = bl;
    cyc = 0; active = 1;
    for (int c = 1; c <= done_c + 1; c++) begin
      @(posedge clk); #1;
      if (abort_cyc > 0 && c == abort_cyc + 1) begin
        rst = 0; active = 0; bus.start = 0;
        break;
      end
      cyc = c;
      e = model(c);
      bus.start     = pulses && (c % 5 == 2) && (c <= done_c);
      bus.rw        = ~rw;
      bus.byte_en   = ~be;
      bus.burst_len = bl + BL_W'(3);
      bus.addr_in    = e.addr_in;
      bus.data_in    = e.data_in;
      bus.mram_rdata = e.rdata;
      if (abort_cyc > 0 && c == abort_cyc) rst = 1;
    end
    if (abort_cyc == 0) begin
      @(negedge clk); #1;
      active = 0;
    end
    bus.start = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_chip_en"}, bus.chip_en, 1'b1);
    check_output({tag, "_write_en"}, bus.write_en, 1'b1);
    check_output({tag, "_out_en"}, bus.out_en, 1'b1);
    check_output({tag, "_lane_en_n"}, bus.lane_en_n, 2'b11);
    check_output({tag, "_data_oe"}, bus.data_oe, 1'b0);
    check_output({tag, "_busy"}, bus.busy, 1'b0);
    check_output({tag, "_done"}, bus.done, 1'b0);
    check_output({tag, "_shift_en"}, bus.shift_en, 1'b0);
    check_output({tag, "_ser_valid"}, bus.ser_valid, 1'b0);
    check_output({tag, "_ser_data_out"}, bus.ser_data_out, 1'b0);
    check_output({tag, "_addr_out"}, bus.addr_out, 20'h0);
    check_output({tag, "_data_out"}, bus.data_out, 16'h0);
  endtask

  initial begin
    rst = 1;
    bus.start = 0; bus.rw = 0; bus.byte_en = '0; bus.burst_len = '0;
    bus.addr_in = 0; bus.data_in = 0; bus.mram_rdata = '0;
    cyc = -1;
    for (int i = 0; i < BURST_MAX; i++) begin
      m_wd[i] = '0;
      m_rd[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");

    // start and rst together: reset must win
    bus.start = 1; bus.rw = 1; bus.byte_en = 2'b11; bus.burst_len = 4'd1;
    @(posedge clk); #1;
    rst = 0; bus.start = 0;
    @(negedge clk);
    check_output("rst_vs_start_busy", bus.busy, 1'b0);
    check_output("rst_vs_start_shift_en", bus.shift_en, 1'b0);

    $display("[TB] single write");
    m_wd[0] = 16'hA5C3;
    apply_stimulus(1'b1, 20'h00005, 2'b11, 4'd1, 1'b0, 0);
    check_output("wr_done_cycle", done_cyc, 41);
    check_output("wr_first_strobe", first_strobe, 37);
    check_output("wr_last_strobe", last_strobe, 39);
    check_output("wr_access_cnt", access_cnt, 1);
    check_output("wr_shift_cnt", shift_cnt, 36);
    check_output("wr_data_out", first_data, 16'hA5C3);
    check_output("wr_lane_en_n", first_lane, 2'b00);
    if (addr_log.size() > 0) check_output("wr_addr", addr_log[0], 20'h00005);

    $display("[TB] single read");
    m_rd[0] = 16'h1234;
    apply_stimulus(1'b0, 20'h0ABCD, 2'b10, 4'd1, 1'b0, 0);
    check_output("rd_done_cycle", done_cyc, 41);
    check_output("rd_first_strobe", first_strobe, 21);
    check_output("rd_last_strobe", last_strobe, 23);
    check_output("rd_ser_word", ser_word, 16'h1200);
    check_output("rd_lane_en_n", first_lane, 2'b01);

    $display("[TB] write burst of 3 across address wrap");
    m_wd[0] = 16'h1111; m_wd[1] = 16'h2BCD; m_wd[2] = 16'hF00F;
    apply_stimulus(1'b1, 20'hFFFFF, 2'b01, 4'd3, 1'b0, 0);
    check_output("wb_access_cnt", access_cnt, 3);
    check_output("wb_shift_cnt", shift_cnt, 68);
    check_output("wb_done_cycle", done_cyc, 81);
    if (addr_log.size() >= 3) begin
      check_output("wb_addr0", addr_log[0], 20'hFFFFF);
      check_output("wb_addr1", addr_log[1], 20'h00000);
      check_output("wb_addr2", addr_log[2], 20'h00001);
    end

    $display("[TB] read burst_len 0 with start pulses while busy");
    m_rd[0] = 16'hC3E7;
    apply_stimulus(1'b0, 20'h12345, 2'b11, 4'd0, 1'b1, 0);
    check_output("r0_access_cnt", access_cnt, 1);
    check_output("r0_done_cnt", done_cnt, 1);
    check_output("r0_done_cycle", done_cyc, 41);
    check_output("r0_ser_word", ser_word, 16'hC3E7);

    $display("[TB] read burst_len 15 clamps to 8");
    for (int i = 0; i < BURST_MAX; i++) m_rd[i] = 16'h0F01 * 16'(i + 1) ^ 16'h5A5A;
    apply_stimulus(1'b0, 20'h00100, 2'b11, 4'd15, 1'b1, 0);
    check_output("clamp_access_cnt", access_cnt, 8);
    check_output("clamp_done_cnt", done_cnt, 1);
    check_output("clamp_done_cycle", done_cyc, 181);

    $display("[TB] reset in the middle of a write access");
    m_wd[0] = 16'h7E81;
    apply_stimulus(1'b1, 20'h0F0F0, 2'b11, 4'd2, 1'b0, 38);
    hold_addr = '0;
    @(negedge clk);
    check_reset_values("abort");
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check_output("abort_quiet_chip_en", bus.chip_en, 1'b1);
      check_output("abort_quiet_busy", bus.busy, 1'b0);
    end

    $display("[TB] single write after abort");
    m_wd[0] = 16'h0180;
    apply_stimulus(1'b1, 20'h54321, 2'b10, 4'd1, 1'b0, 0);
    check_output("post_done_cycle", done_cyc, 41);
    check_output("post_access_cnt", access_cnt, 1);
    check_output("post_lane_en_n", first_lane, 2'b01);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
